// File: rtl/lustre_step_scheduler_if.sv
// Handshake bundle between the environment, the scheduler and the node.
// The environment (master) offers samples and consumes outputs.
interface lustre_step_scheduler_if #(
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic             in_capture;
  logic             restart;
  logic             node_init;
  logic             node_step;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] instant;

  modport master (
    output in_valid,
    output restart,
    output out_ready,
    input  in_ready,
    input  in_capture,
    input  node_init,
    input  node_step,
    input  out_valid,
    input  instant
  );

  modport slave (
    input  in_valid,
    input  restart,
    input  out_ready,
    output in_ready,
    output in_capture,
    output node_init,
    output node_step,
    output out_valid,
    output instant
  );
endinterface

// File: rtl/lustre_step_scheduler.sv
// Sequences one Lustre instant: capture, evaluate, present, commit.
// Owns the node's first-instant flag and the restart semantics.
module lustre_step_scheduler #(
  parameter int LATENCY = 1,
  parameter int CNT_W   = 16
) (
  input logic                    clock,
  input logic                    reset_n,
  lustre_step_scheduler_if.slave bus
);

  if (LATENCY < 1 || LATENCY > 255) begin : g_bad_latency
    $error("lustre_step_scheduler: LATENCY must be 1..255");
  end

  typedef enum logic [1:0] {
    IDLE,
    EVAL,
    OUTPUT
  } state_t;

  localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

  state_t           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             init_q, init_d;
  logic             pend_q, pend_d;
  logic [CNT_W-1:0] inst_q, inst_d;

  logic in_ready;
  logic out_valid;
  logic step;
  logic rst_now;

  // Instant FSM: next state, wait counter and handshake outputs.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    step      = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          state_d = EVAL;
          cnt_d   = LAT_M1;
        end
      end
      EVAL: begin
        if (cnt_q == 8'd0) begin
          state_d = OUTPUT;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      OUTPUT: begin
        out_valid = 1'b1;
        if (bus.out_ready) begin
          // A reset in this cycle discards the instant uncommitted.
          step    = reset_n;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Init flag, pending restart and instant index updates.
  always_comb begin
    init_d  = init_q;
    pend_d  = pend_q;
    inst_d  = inst_q;
    rst_now = pend_q | bus.restart;
    if (step) begin
      init_d = rst_now;
      pend_d = 1'b0;
      inst_d = rst_now ? '0 : inst_q + CNT_W'(1);
    end else if (bus.restart) begin
      if (state_q == IDLE) begin
        init_d = 1'b1;
        inst_d = '0;
      end else begin
        pend_d = 1'b1;
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      init_q  <= 1'b1;
      pend_q  <= 1'b0;
      inst_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      init_q  <= init_d;
      pend_q  <= pend_d;
      inst_q  <= inst_d;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.in_capture = bus.in_valid & in_ready;
  assign bus.out_valid  = out_valid;
  assign bus.node_step  = step;
  assign bus.node_init  = init_q;
  assign bus.instant    = inst_q;

endmodule
